// File: rtl/prbs15_checker.sv
// PRBS15 (x^15+x^14+1) serial bit-error checker: acquires sync, then runs a
// flywheel predictor that counts bit errors and drops lock on error bursts.
module prbs15_checker #(
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned UNLOCK_ERR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_valid,
    input  logic        din,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    localparam int unsigned HIST_W  = 15;
    localparam int unsigned FILL_W  = 4;
    localparam int unsigned MATCH_W = 8;
    localparam int unsigned WIN_W   = 16;
    localparam int unsigned ERR_W   = 16;
    localparam int unsigned BIT_W   = 32;

    typedef enum logic [1:0] {
        S_FILL,
        S_SEARCH,
        S_LOCKED
    } state_t;

    state_t               state, state_nx;
    logic [HIST_W-1:0]    hist, hist_nx;
    logic [FILL_W-1:0]    fill_cnt, fill_nx;
    logic [MATCH_W-1:0]   match_cnt, match_nx;
    logic [WIN_W-1:0]     win_cnt, win_cnt_nx;
    logic [WIN_W-1:0]     win_err, win_err_nx;
    logic [WIN_W-1:0]     win_err_inc;
    logic                 locked_nx, pulse_nx;
    logic [ERR_W-1:0]     err_count_nx;
    logic [BIT_W-1:0]     bit_count_nx;
    logic                 expected, mismatch;

    assign expected    = hist[14] ^ hist[13];
    assign mismatch    = din ^ expected;
    assign win_err_inc = win_err + WIN_W'(mismatch);

    // Next-state and next-output logic; every register holds unless a valid bit arrives.
    always_comb begin
        state_nx     = state;
        hist_nx      = hist;
        fill_nx      = fill_cnt;
        match_nx     = match_cnt;
        win_cnt_nx   = win_cnt;
        win_err_nx   = win_err;
        pulse_nx     = 1'b0;
        err_count_nx = err_count;
        bit_count_nx = bit_count;

        if (din_valid) begin
            case (state)
                S_FILL: begin
                    hist_nx = {hist[13:0], din};
                    if (fill_cnt == FILL_W'(HIST_W - 1)) begin
                        state_nx = S_SEARCH;
                        fill_nx  = '0;
                        match_nx = '0;
                    end else begin
                        fill_nx = fill_cnt + FILL_W'(1);
                    end
                end
                S_SEARCH: begin
                    hist_nx = {hist[13:0], din};
                    // A match against an all-zero history is meaningless and restarts the count.
                    if (!mismatch && (hist != '0)) begin
                        if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state_nx   = S_LOCKED;
                            match_nx   = '0;
                            win_cnt_nx = '0;
                            win_err_nx = '0;
                        end else begin
                            match_nx = match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        match_nx = '0;
                    end
                end
                S_LOCKED: begin
                    // Flywheel: feed back the prediction so one channel error costs one pulse.
                    hist_nx  = {hist[13:0], expected};
                    pulse_nx = mismatch;
                    if (bit_count != '1)
                        bit_count_nx = bit_count + BIT_W'(1);
                    if (mismatch && (err_count != '1))
                        err_count_nx = err_count + ERR_W'(1);
                    if (win_err_inc >= WIN_W'(UNLOCK_ERR)) begin
                        state_nx   = S_FILL;
                        fill_nx    = '0;
                        win_cnt_nx = '0;
                        win_err_nx = '0;
                    end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        win_cnt_nx = '0;
                        win_err_nx = '0;
                    end else begin
                        win_cnt_nx = win_cnt + WIN_W'(1);
                        win_err_nx = win_err_inc;
                    end
                end
                default: begin
                    state_nx = S_FILL;
                    fill_nx  = '0;
                end
            endcase
        end

        if (clear) begin
            err_count_nx = '0;
            bit_count_nx = '0;
        end

        locked_nx = (state_nx == S_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FILL;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            state     <= state_nx;
            hist      <= hist_nx;
            fill_cnt  <= fill_nx;
            match_cnt <= match_nx;
            win_cnt   <= win_cnt_nx;
            win_err   <= win_err_nx;
            locked    <= locked_nx;
            err_pulse <= pulse_nx;
            err_count <= err_count_nx;
            bit_count <= bit_count_nx;
        end
    end

endmodule

// File: tb/tb_prbs15_checker.sv
// Scoreboard bench for prbs15_checker: directed scenarios plus randomized
// traffic, checked against a queue-based behavioural model.
module tb_prbs15_checker;

    localparam int unsigned LOCK_CNT   = 32;
    localparam int unsigned WINDOW     = 64;
    localparam int unsigned UNLOCK_ERR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    always #5 clk = ~clk;

    prbs15_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .WINDOW    (WINDOW),
        .UNLOCK_ERR(UNLOCK_ERR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din_valid(din_valid),
        .din      (din),
        .clear    (clear),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .bit_count(bit_count)
    );

    typedef struct {
        bit              lk;
        bit              pl;
        int unsigned     ec;
        longint unsigned bc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: mode 0 = filling, 1 = searching, 2 = locked.
    int              mode;
    bit              hist[$];
    int              fill_n, match_n, wcnt, werr;
    int unsigned     m_err;
    longint unsigned m_bits;
    logic [14:0]     gen;

    function automatic bit gen_bit();
        bit b;
        b   = gen[14] ^ gen[13];
        gen = {gen[13:0], b};
        return b;
    endfunction

    function automatic void model_reset();
        mode = 0;
        hist.delete();
        for (int i = 0; i < 15; i++) hist.push_back(1'b0);
        fill_n  = 0;
        match_n = 0;
        wcnt    = 0;
        werr    = 0;
        m_err   = 0;
        m_bits  = 0;
    endfunction

    function automatic void model_step(input bit v, input bit d, input bit c, output bit pulse);
        bit e, nz, mis;
        pulse = 1'b0;
        if (v) begin
            e = hist[0] ^ hist[1];
            if (mode == 0) begin
                hist.push_back(d);
                fill_n++;
                if (fill_n == 15) begin
                    mode    = 1;
                    match_n = 0;
                end
            end else if (mode == 1) begin
                nz = 1'b0;
                foreach (hist[i]) nz |= hist[i];
                if (d == e && nz) match_n++;
                else match_n = 0;
                hist.push_back(d);
                if (match_n == int'(LOCK_CNT)) begin
                    mode    = 2;
                    match_n = 0;
                    wcnt    = 0;
                    werr    = 0;
                end
            end else begin
                mis = (d != e);
                hist.push_back(e);
                pulse = mis;
                if (m_bits != 64'hFFFF_FFFF) m_bits++;
                if (mis && m_err != 32'hFFFF) m_err++;
                wcnt++;
                werr += int'(mis);
                if (werr >= int'(UNLOCK_ERR)) begin
                    mode   = 0;
                    fill_n = 0;
                    wcnt   = 0;
                    werr   = 0;
                end else if (wcnt == int'(WINDOW)) begin
                    wcnt = 0;
                    werr = 0;
                end
            end
            while (hist.size() > 15) void'(hist.pop_front());
        end
        if (c) begin
            m_err  = 0;
            m_bits = 0;
        end
    endfunction

    function automatic void cmp(input string name, input longint unsigned act, input longint unsigned expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    // One input cycle: drive at negedge, push the expected post-edge outputs.
    task automatic step(input bit v, input bit d, input bit c, input bit r);
        exp_t x;
        bit   p;
        bit   was;
        @(negedge clk);
        din_valid = v;
        din       = d;
        clear     = c;
        p         = 1'b0;
        if (r) begin
            was = rst;
            rst = 1'b1;
            model_reset();
            if (!was) begin
                #1;
                cmp("rst_immediate", {locked, err_pulse, err_count, bit_count}, 0);
            end
        end else begin
            rst = 1'b0;
            model_step(v, d, c, p);
        end
        x.lk = (mode == 2);
        x.pl = p;
        x.ec = m_err;
        x.bc = m_bits;
        sbq.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(1'b1, gen_bit(), 1'b0, 1'b0);
    endtask

    task automatic errbit(input bit c);
        step(1'b1, ~gen_bit(), c, 1'b0);
    endtask

    // Monitor: compare every registered output set against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                checks++;
                if (locked !== x.lk || err_pulse !== x.pl ||
                    32'(err_count) !== x.ec || 64'(bit_count) !== x.bc) begin
                    errors++;
                    $display("FAIL scoreboard at %0t: got lk=%0b pl=%0b ec=%0d bc=%0d expected lk=%0b pl=%0b ec=%0d bc=%0d",
                             $time, locked, err_pulse, err_count, bit_count, x.lk, x.pl, x.ec, x.bc);
                end
            end
        end
    end

    initial begin
        bit v, b, f, c;
        gen = 15'h0001;
        model_reset();

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        clean(46);
        settle();
        cmp("locked_before_47", locked, 0);
        clean(1);
        settle();
        cmp("locked_at_47", locked, 1);

        clean(100);
        settle();
        cmp("bit_count_100", bit_count, 100);
        cmp("err_count_clean", err_count, 0);

        errbit(1'b0);
        settle();
        cmp("single_err_pulse", err_pulse, 1);
        cmp("single_err_count", err_count, 1);
        cmp("single_err_locked", locked, 1);
        clean(100);
        settle();
        cmp("after_single_err_count", err_count, 1);
        cmp("after_single_locked", locked, 1);

        for (int k = 0; k < 4; k++) begin
            clean(4);
            errbit(1'b0);
        end
        settle();
        cmp("unlock_after_4", locked, 0);

        clean(47);
        settle();
        cmp("relock", locked, 1);

        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 640; i++) begin
            if ((i % 64) == 10 || (i % 64) == 30 || (i % 64) == 50) errbit(1'b0);
            else clean(1);
        end
        settle();
        cmp("3_per_window_locked", locked, 1);
        cmp("3_per_window_err_count", err_count, 30);
        cmp("3_per_window_bit_count", bit_count, 640);

        errbit(1'b1);
        settle();
        cmp("clear_pulse", err_pulse, 1);
        cmp("clear_err_count", err_count, 0);
        cmp("clear_bit_count", bit_count, 0);

        for (int k = 0; k < 5; k++) begin
            clean(29);
            errbit(1'b0);
        end
        settle();
        cmp("five_err_count", err_count, 5);
        cmp("five_err_locked", locked, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        clean(46);
        settle();
        cmp("post_rst_not_locked", locked, 0);
        clean(1);
        settle();
        cmp("post_rst_relock", locked, 1);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 92; i++) begin
            if ((i % 2) == 0) clean(1);
            else step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        settle();
        cmp("toggle_before_lock", locked, 0);
        clean(1);
        settle();
        cmp("toggle_lock_94", locked, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        cmp("zeros_locked", locked, 0);
        cmp("zeros_err_count", err_count, 0);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            b = v ? gen_bit() : 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 199) == 0);
            step(v, b ^ f, c, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        cmp("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
